counter_wrap_monitor: RTL and testbench
=======================================

COUNTER_WRAP_MONITOR -- requirements
Module: counter_wrap_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the width of the monitored count.
REQ-002 SHALL have parameter EXT_WIDTH, default 4, giving the width of the wrap counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port q, input, WIDTH bits: the count from the upstream up/down counter.
REQ-006 SHALL have port ctrl, input, 1 bit: the counter direction; 1 = up, 0 = down.
REQ-007 SHALL have port ext_count, output, WIDTH+EXT_WIDTH bits: the extended count {wraps, q}.
REQ-008 SHALL have port wrap_up, output, 1 bit: one-cycle pulse on an up-wrap from all-ones to zero.
REQ-009 SHALL have port wrap_dn, output, 1 bit: one-cycle pulse on a down-wrap from zero to all-ones.
REQ-010 SHALL have port step_err, output, 1 bit: sticky flag for an illegal step.
REQ-011 SHALL have port valid, output, 1 bit: high while ext_count is being tracked.

Function
REQ-012 SHALL register q and ctrl every cycle into q_d and ctrl_d, so each step is judged against the direction in force when the step was made.
REQ-013 SHALL implement the FSM INIT -> TRACK -> FAULT; FAULT exits only on rst.
REQ-014 In INIT, SHALL capture q and ctrl, load ext_count = {0, q}, and move to TRACK with no step check.
REQ-015 In TRACK, SHALL classify each step by delta = (q - q_d) mod 2^WIDTH.
REQ-016 HOLD: delta = 0 is legal for either direction, and ext_count is unchanged.
REQ-017 UP: delta = 1 with ctrl_d = 1 is legal, and ext_count = {wraps, q}.
REQ-018 DOWN: delta = all-ones (-1) with ctrl_d = 0 is legal, and ext_count = {wraps, q}.
REQ-019 On an UP step with q_d = all-ones and q = 0, SHALL increment wraps mod 2^EXT_WIDTH and pulse wrap_up for exactly one cycle.
REQ-020 On a DOWN step with q_d = 0 and q = all-ones, SHALL decrement wraps mod 2^EXT_WIDTH and pulse wrap_dn for exactly one cycle.
REQ-021 Any other step SHALL be illegal: a direction mismatch, or |delta| > 1.
REQ-022 On an illegal step, SHALL set step_err, enter FAULT, and clear valid.
REQ-023 In FAULT, SHALL freeze ext_count, keep wrap_up and wrap_dn low, and hold step_err at 1.
REQ-024 All outputs SHALL be registered, with one cycle of latency from a q change to the ext_count and pulse update.
REQ-025 wrap_up and wrap_dn SHALL never be high in the same cycle.
REQ-026 valid SHALL be 1 exactly in the cycles the FSM is in TRACK.

Reset
REQ-027 rst high at a clock edge SHALL force INIT, wraps = 0, q_d = 0, ctrl_d = 0, ext_count = 0, wrap_up = 0, wrap_dn = 0, step_err = 0 and valid = 0.
REQ-028 rst SHALL take priority over every concurrent event, including a wrap, an illegal step, and FAULT.
REQ-029 rst asserted mid-operation SHALL discard the wrap history.
REQ-030 After rst deasserts, the first edge SHALL be the INIT capture and no step check SHALL be made on it.

Structure
REQ-031 A shared package counter_pkg SHALL hold:
- the FSM state typedef (INIT, TRACK, FAULT);
- the step-class typedef (HOLD, UP, DOWN, ILLEGAL);
- the constants DIR_UP = 1 and DIR_DN = 0.
REQ-032 A combinational sub-module step_classifier SHALL map (q_d, q, ctrl_d) to a step class plus wrap-up and wrap-down indicators.
REQ-033 The FSM and all registers SHALL reside in counter_wrap_monitor.

Verification
REQ-034 Reset then up-count: rst for 2 cycles, then ctrl = 1 and q steps 0..15 -> 0 -> 1.
- Required: valid = 1 from the first post-reset cycle.
- Required: one wrap_up pulse, one cycle after q = 0 appears.
- Required: ext_count = 8'h10, then 8'h11.
REQ-035 Down-wrap: from ext_count = 8'h10 with ctrl = 0, q goes 0 -> 15 -> 14.
- Required: one wrap_dn pulse.
- Required: ext_count = 8'h0F, then 8'h0E.
- Required: step_err stays 0.
REQ-036 Hold: q held at 7 for 5 cycles in either direction.
- Required: ext_count is constant.
- Required: no pulses and no error.
REQ-037 Illegal step: q jumps 3 -> 5, or steps 3 -> 4 with ctrl_d = 0.
- Required: step_err = 1 and valid = 0 on the next cycle.
- Required: ext_count stays frozen through 10 further cycles of legal counting.
REQ-038 Reset priority: rst asserted in the same cycle as a 15 -> 0 up-wrap, and again while in FAULT.
- Required: no wrap_up pulse.
- Required: all outputs are 0 on the next cycle.
- Required: INIT is re-entered and tracking restarts with wraps = 0.
REQ-039 Wrap modulo: 16 consecutive up-wraps.
- Required: the wraps field returns to 0.
- Required: 16 wrap_up pulses and no error.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and constants for the counter wrap monitor: FSM states,
// step classes and the direction encoding of the upstream counter.
package counter_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        UP      = 2'd1,
        DOWN    = 2'd2,
        ILLEGAL = 2'd3
    } step_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // True when the step class advances the tracked count (UP or DOWN).
    function automatic logic is_move(input step_t step);
        return (step == UP) || (step == DOWN);
    endfunction

endpackage

// File: rtl/counter_wrap_monitor_step_classifier.sv
// Classifies one step of the upstream counter from its previous value and
// direction to its current value, flagging the two wrap-around steps.
module step_classifier
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q_d,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_ctrl_d,
    output step_t            o_step,
    output logic             o_wrap_up,
    output logic             o_wrap_dn
);

    logic [WIDTH-1:0] w_delta;
    logic [WIDTH-1:0] w_one;

    assign w_delta = i_q - i_q_d;
    assign w_one   = WIDTH'(1);

    // Direction is checked on every non-zero delta, so with WIDTH = 1 (where
    // +1 and -1 coincide) the registered direction decides the class.
    always_comb begin
        o_step = ILLEGAL;
        if (w_delta == '0) begin
            o_step = HOLD;
        end else if ((w_delta == w_one) && (i_ctrl_d == DIR_UP)) begin
            o_step = UP;
        end else if ((w_delta == '1) && (i_ctrl_d == DIR_DN)) begin
            o_step = DOWN;
        end
    end

    assign o_wrap_up = (o_step == UP)   && (i_q_d == '1);
    assign o_wrap_dn = (o_step == DOWN) && (i_q_d == '0);

endmodule

// File: rtl/counter_wrap_monitor.sv
// Extends an up/down counter's value with a wrap count, pulsing on each wrap
// and latching a sticky error (until reset) on any step a counter cannot make.
module counter_wrap_monitor
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EXT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               q,
    input  logic                           ctrl,
    output logic [WIDTH+EXT_WIDTH-1:0]     ext_count,
    output logic                           wrap_up,
    output logic                           wrap_dn,
    output logic                           step_err,
    output logic                           valid
);

    state_t                         r_state;
    logic [WIDTH-1:0]               r_q_d;
    logic                           r_ctrl_d;
    logic [EXT_WIDTH-1:0]           r_wraps;
    logic [WIDTH+EXT_WIDTH-1:0]     r_ext_count;
    logic                           r_wrap_up;
    logic                           r_wrap_dn;
    logic                           r_step_err;
    logic                           r_valid;

    step_t                          w_step;
    logic                           w_is_wrap_up;
    logic                           w_is_wrap_dn;
    logic [EXT_WIDTH-1:0]           w_wraps_next;

    step_classifier #(
        .WIDTH (WIDTH)
    ) u_step_classifier (
        .i_q_d     (r_q_d),
        .i_q       (q),
        .i_ctrl_d  (r_ctrl_d),
        .o_step    (w_step),
        .o_wrap_up (w_is_wrap_up),
        .o_wrap_dn (w_is_wrap_dn)
    );

    always_comb begin
        w_wraps_next = r_wraps;
        if (w_is_wrap_up) begin
            w_wraps_next = r_wraps + EXT_WIDTH'(1);
        end else if (w_is_wrap_dn) begin
            w_wraps_next = r_wraps - EXT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT;
            r_q_d       <= '0;
            r_ctrl_d    <= DIR_DN;
            r_wraps     <= '0;
            r_ext_count <= '0;
            r_wrap_up   <= 1'b0;
            r_wrap_dn   <= 1'b0;
            r_step_err  <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            // The previous sample is refreshed in every state so that the
            // first TRACK cycle compares against the INIT capture.
            r_q_d     <= q;
            r_ctrl_d  <= ctrl;
            r_wrap_up <= 1'b0;
            r_wrap_dn <= 1'b0;

            case (r_state)
                INIT: begin
                    r_wraps     <= '0;
                    r_ext_count <= {{EXT_WIDTH{1'b0}}, q};
                    r_valid     <= 1'b1;
                    r_state     <= TRACK;
                end
                TRACK: begin
                    if (w_step == ILLEGAL) begin
                        r_step_err <= 1'b1;
                        r_valid    <= 1'b0;
                        r_state    <= FAULT;
                    end else if (is_move(w_step)) begin
                        r_wraps     <= w_wraps_next;
                        r_ext_count <= {w_wraps_next, q};
                        r_wrap_up   <= w_is_wrap_up;
                        r_wrap_dn   <= w_is_wrap_dn;
                    end
                end
                FAULT: begin
                    r_step_err <= 1'b1;
                    r_valid    <= 1'b0;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign ext_count = r_ext_count;
    assign wrap_up   = r_wrap_up;
    assign wrap_dn   = r_wrap_dn;
    assign step_err  = r_step_err;
    assign valid     = r_valid;

endmodule

// File: tb/tb_counter_wrap_monitor.sv
// Directed-vector bench for counter_wrap_monitor with WIDTH = 4, EXT_WIDTH = 4.
module tb_counter_wrap_monitor;

    logic       clk;
    logic       rst;
    logic [3:0] q;
    logic       ctrl;
    logic [7:0] ext_count;
    logic       wrap_up;
    logic       wrap_dn;
    logic       step_err;
    logic       valid;

    int n_total = 0;
    int n_bad   = 0;
    int n_txn   = 0;

    counter_wrap_monitor #(
        .WIDTH     (4),
        .EXT_WIDTH (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .q         (q),
        .ctrl      (ctrl),
        .ext_count (ext_count),
        .wrap_up   (wrap_up),
        .wrap_dn   (wrap_dn),
        .step_err  (step_err),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one input vector, clock it in, and sample just after the edge.
    task automatic tick(input logic [3:0] qv, input logic cv, input logic rv);
        q    = qv;
        ctrl = cv;
        rst  = rv;
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d rst=%0b q=%0h ctrl=%0b -> ext=%02h up=%0b dn=%0b err=%0b valid=%0b",
                 n_txn, rv, qv, cv, ext_count, wrap_up, wrap_dn, step_err, valid);
    endtask

    task automatic check_outs(input string tag, input logic [7:0] e_ext, input logic e_up,
                              input logic e_dn, input logic e_err, input logic e_valid);
        check({tag, ".ext"},   32'(ext_count), 32'(e_ext));
        check({tag, ".up"},    32'(wrap_up),   32'(e_up));
        check({tag, ".dn"},    32'(wrap_dn),   32'(e_dn));
        check({tag, ".err"},   32'(step_err),  32'(e_err));
        check({tag, ".valid"}, 32'(valid),     32'(e_valid));
    endtask

    initial begin
        logic [3:0] qv;
        logic [3:0] wraps_exp;
        int         up_pulses;

        q = 4'h0; ctrl = 1'b0; rst = 1'b1;

        // Reset for two cycles, then up-count through one wrap.
        tick(4'h0, 1'b0, 1'b1);
        tick(4'h0, 1'b0, 1'b1);
        check_outs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'h0, 1'b1, 1'b0);
        check_outs("init_capture", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        up_pulses = 0;
        for (int i = 1; i < 16; i++) begin
            tick(4'(i), 1'b1, 1'b0);
            check("upcount.ext", 32'(ext_count), 32'(i));
            if (wrap_up) up_pulses++;
        end
        check("upcount.no_early_wrap", 32'(up_pulses), 32'd0);
        tick(4'h0, 1'b1, 1'b0);
        check_outs("upwrap", 8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(4'h1, 1'b1, 1'b0);
        check_outs("after_upwrap", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);

        // Turn around (hold while ctrl flips), then down-wrap 0 -> 15 -> 14.
        tick(4'h1, 1'b0, 1'b0);
        check_outs("turnaround_hold", 8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(4'h0, 1'b0, 1'b0);
        check_outs("down_to_10", 8'h10, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(4'hF, 1'b0, 1'b0);
        check_outs("downwrap", 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1);
        tick(4'hE, 1'b0, 1'b0);
        check_outs("after_downwrap", 8'h0E, 1'b0, 1'b0, 1'b0, 1'b1);

        // Count down to 7, then hold there in both directions.
        for (int i = 13; i >= 7; i--) begin
            tick(4'(i), 1'b0, 1'b0);
            check("downcount.ext", 32'(ext_count), 32'(i));
        end
        for (int i = 0; i < 10; i++) begin
            tick(4'h7, (i >= 5) ? 1'b1 : 1'b0, 1'b0);
            check_outs("hold7", 8'h07, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Illegal jump 3 -> 5, then legal counting (including a wrap) stays frozen.
        tick(4'h3, 1'b1, 1'b1);
        tick(4'h3, 1'b1, 1'b0);
        check_outs("init_at_3", 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(4'h5, 1'b1, 1'b0);
        check_outs("jump_3_5", 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
        qv = 4'h5;
        for (int i = 0; i < 11; i++) begin
            qv = qv + 4'h1;
            tick(qv, 1'b1, 1'b0);
            check_outs("fault_frozen", 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
        end

        // Reset while in FAULT clears everything; then a direction mismatch 3 -> 4.
        tick(4'h0, 1'b1, 1'b1);
        check_outs("rst_in_fault", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'h3, 1'b0, 1'b0);
        check_outs("init_dn_at_3", 8'h03, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(4'h4, 1'b0, 1'b0);
        check_outs("dir_mismatch", 8'h03, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset coinciding with a 15 -> 0 up-wrap wins; wraps restart at 0.
        tick(4'hE, 1'b1, 1'b1);
        tick(4'hE, 1'b1, 1'b0);
        check_outs("init_at_e", 8'h0E, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(4'hF, 1'b1, 1'b0);
        check_outs("up_to_f", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(4'h0, 1'b1, 1'b1);
        check_outs("rst_on_wrap", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'h1, 1'b1, 1'b0);
        check_outs("reinit", 8'h01, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(4'h2, 1'b1, 1'b0);
        check_outs("retrack", 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

        // Sixteen consecutive up-wraps bring the wraps field back to 0.
        qv        = 4'h2;
        wraps_exp = 4'h0;
        up_pulses = 0;
        for (int i = 0; i < 256; i++) begin
            qv = qv + 4'h1;
            tick(qv, 1'b1, 1'b0);
            if (qv == 4'h0) wraps_exp = wraps_exp + 4'h1;
            check("modulo.ext", 32'(ext_count), 32'({wraps_exp, qv}));
            check("modulo.up", 32'(wrap_up), 32'(qv == 4'h0));
            if (wrap_up) up_pulses++;
            if (wrap_dn || step_err) check("modulo.dn_err", 32'({wrap_dn, step_err}), 32'd0);
        end
        check("modulo.pulses", 32'(up_pulses), 32'd16);
        check("modulo.wraps_field", 32'(ext_count[7:4]), 32'd0);
        check("modulo.err", 32'(step_err), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
